// File: rtl/any1_pkg.sv
// Shared types, branch opcodes and arbiter FSM states for the any1 branch unit.
package any1_pkg;

    typedef logic [31:0] Instruction;
    typedef logic [63:0] Value;
    typedef logic [31:0] Address;

    // Branch opcode lives in the low byte of the instruction word.
    localparam logic [7:0] OP_BEQ  = 8'h40;
    localparam logic [7:0] OP_BNE  = 8'h41;
    localparam logic [7:0] OP_BLT  = 8'h42;
    localparam logic [7:0] OP_BGE  = 8'h43;
    localparam logic [7:0] OP_BLTU = 8'h44;
    localparam logic [7:0] OP_BGEU = 8'h45;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_OUT  = 2'd2
    } br_state_e;

    function automatic logic [7:0] br_opcode(input Instruction inst);
        return inst[7:0];
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/any1_eval_branch.sv
// Combinational branch-condition evaluator; unknown opcodes resolve not-taken.
module any1_eval_branch
    import any1_pkg::*;
(
    input  Instruction inst_i,
    input  Value       a_i,
    input  Value       b_i,
    output logic       takb_o
);

    always_comb begin
        takb_o = 1'b0;
        case (br_opcode(inst_i))
            OP_BEQ:  takb_o = (a_i == b_i);
            OP_BNE:  takb_o = (a_i != b_i);
            OP_BLT:  takb_o = ($signed(a_i) <  $signed(b_i));
            OP_BGE:  takb_o = ($signed(a_i) >= $signed(b_i));
            OP_BLTU: takb_o = (a_i <  b_i);
            OP_BGEU: takb_o = (a_i >= b_i);
            default: takb_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/any1_branch_arbiter.sv
// Two-requester round-robin front end sharing one branch evaluator.
// A grant latches operands, the next edge registers the result, which is held until taken.
module any1_branch_arbiter
    import any1_pkg::*;
#(
    parameter int unsigned INST_BYTES  = 4,
    parameter int unsigned TAGW        = 4,
    parameter logic [31:0] CNT_RST_VAL = 32'h0000_0000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req0_v_i,
    output logic             req0_rdy_o,
    input  Instruction       req0_inst_i,
    input  Value             req0_a_i,
    input  Value             req0_b_i,
    input  Address           req0_pc_i,
    input  Address           req0_tgt_i,
    input  logic             req0_pred_i,
    input  logic [TAGW-1:0]  req0_tag_i,
    input  logic             req1_v_i,
    output logic             req1_rdy_o,
    input  Instruction       req1_inst_i,
    input  Value             req1_a_i,
    input  Value             req1_b_i,
    input  Address           req1_pc_i,
    input  Address           req1_tgt_i,
    input  logic             req1_pred_i,
    input  logic [TAGW-1:0]  req1_tag_i,
    input  logic             flush_i,
    output logic             res_v_o,
    input  logic             res_rdy_i,
    output logic             res_src_o,
    output logic [TAGW-1:0]  res_tag_o,
    output logic             res_takb_o,
    output logic             res_mispred_o,
    output Address           res_npc_o,
    output logic [31:0]      cnt_br_o,
    output logic [31:0]      cnt_mis_o
);

    br_state_e        state_q, state_d;
    logic             ptr_q;
    logic             can_accept_s, grant_s, gnt_idx_s, deliver_s, takb_s;
    Instruction       inst_q;
    Value             a_q, b_q;
    Address           pc_q, tgt_q;
    logic             pred_q, src_q;
    logic [TAGW-1:0]  tag_q;
    logic             res_src_q, res_takb_q, res_mis_q;
    logic [TAGW-1:0]  res_tag_q;
    Address           res_npc_q;
    logic [31:0]      cnt_br_q, cnt_mis_q;

    any1_eval_branch u_eval (
        .inst_i (inst_q),
        .a_i    (a_q),
        .b_i    (b_q),
        .takb_o (takb_s)
    );

    // Arbitration: a refill is only possible from IDLE or a draining OUT; reset masks grants.
    always_comb begin
        if (!rst_ni || flush_i) begin
            can_accept_s = 1'b0;
        end else if (state_q == ST_IDLE) begin
            can_accept_s = 1'b1;
        end else if (state_q == ST_OUT) begin
            can_accept_s = res_rdy_i;
        end else begin
            can_accept_s = 1'b0;
        end
        if (req0_v_i && req1_v_i) begin
            gnt_idx_s = ptr_q;
        end else begin
            gnt_idx_s = req1_v_i;
        end
        grant_s   = can_accept_s && (req0_v_i || req1_v_i);
        deliver_s = (state_q == ST_OUT) && res_rdy_i && !flush_i;
    end

    assign req0_rdy_o = grant_s && !gnt_idx_s;
    assign req1_rdy_o = grant_s &&  gnt_idx_s;

    // Next-state logic; flush overrides any handshake.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = grant_s ? ST_EVAL : ST_IDLE;
                ST_EVAL: state_d = ST_OUT;
                ST_OUT: begin
                    if (grant_s) begin
                        state_d = ST_EVAL;
                    end else if (res_rdy_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_OUT;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output decode from the state register only.
    always_comb begin
        res_v_o = (state_q == ST_OUT);
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand latch and round-robin pointer, updated only on a grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q  <= 1'b0;
            inst_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            pc_q   <= '0;
            tgt_q  <= '0;
            pred_q <= 1'b0;
            tag_q  <= '0;
            src_q  <= 1'b0;
        end else if (grant_s) begin
            ptr_q  <= ~gnt_idx_s;
            inst_q <= gnt_idx_s ? req1_inst_i : req0_inst_i;
            a_q    <= gnt_idx_s ? req1_a_i    : req0_a_i;
            b_q    <= gnt_idx_s ? req1_b_i    : req0_b_i;
            pc_q   <= gnt_idx_s ? req1_pc_i   : req0_pc_i;
            tgt_q  <= gnt_idx_s ? req1_tgt_i  : req0_tgt_i;
            pred_q <= gnt_idx_s ? req1_pred_i : req0_pred_i;
            tag_q  <= gnt_idx_s ? req1_tag_i  : req0_tag_i;
            src_q  <= gnt_idx_s;
        end
    end

    // Result register, written at the end of EVAL unless the op is being flushed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_src_q  <= 1'b0;
            res_tag_q  <= '0;
            res_takb_q <= 1'b0;
            res_mis_q  <= 1'b0;
            res_npc_q  <= '0;
        end else if ((state_q == ST_EVAL) && !flush_i) begin
            res_src_q  <= src_q;
            res_tag_q  <= tag_q;
            res_takb_q <= takb_s;
            res_mis_q  <= (takb_s != pred_q);
            res_npc_q  <= takb_s ? tgt_q : (pc_q + Address'(INST_BYTES));
        end
    end

    // Saturating statistics, counted only on a completed handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_br_q  <= CNT_RST_VAL;
            cnt_mis_q <= CNT_RST_VAL;
        end else if (deliver_s) begin
            cnt_br_q  <= sat_inc32(cnt_br_q);
            cnt_mis_q <= res_mis_q ? sat_inc32(cnt_mis_q) : cnt_mis_q;
        end
    end

    assign res_src_o     = res_src_q;
    assign res_tag_o     = res_tag_q;
    assign res_takb_o    = res_takb_q;
    assign res_mispred_o = res_mis_q;
    assign res_npc_o     = res_npc_q;
    assign cnt_br_o      = cnt_br_q;
    assign cnt_mis_o     = cnt_mis_q;

endmodule

// File: tb/tb_any1_branch_arbiter.sv
// Self-checking bench: per-cycle transaction model plus directed scenarios with literal expectations.
module tb_any1_branch_arbiter;
    import any1_pkg::*;

    logic clk, rst_n;
    logic v0, v1, pred0, pred1, flush, res_rdy;
    Instruction inst0, inst1;
    Value a0, b0, a1, b1;
    Address pc0, tgt0, pc1, tgt1;
    logic [3:0] tag0, tag1;
    logic rdy0, rdy1, res_v, res_src, res_takb, res_mis;
    logic [3:0] res_tag;
    Address res_npc;
    logic [31:0] cnt_br, cnt_mis;
    logic s_rdy0, s_rdy1, s_res_v, s_res_src, s_res_takb, s_res_mis;
    logic [3:0] s_res_tag;
    Address s_res_npc;
    logic [31:0] s_cnt_br, s_cnt_mis;

    int n_chk = 0;
    int n_err = 0;

    any1_branch_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_v_i(v0), .req0_rdy_o(rdy0), .req0_inst_i(inst0), .req0_a_i(a0), .req0_b_i(b0),
        .req0_pc_i(pc0), .req0_tgt_i(tgt0), .req0_pred_i(pred0), .req0_tag_i(tag0),
        .req1_v_i(v1), .req1_rdy_o(rdy1), .req1_inst_i(inst1), .req1_a_i(a1), .req1_b_i(b1),
        .req1_pc_i(pc1), .req1_tgt_i(tgt1), .req1_pred_i(pred1), .req1_tag_i(tag1),
        .flush_i(flush), .res_v_o(res_v), .res_rdy_i(res_rdy), .res_src_o(res_src),
        .res_tag_o(res_tag), .res_takb_o(res_takb), .res_mispred_o(res_mis), .res_npc_o(res_npc),
        .cnt_br_o(cnt_br), .cnt_mis_o(cnt_mis)
    );

    // Second instance with counters preloaded near the top, to exercise saturation.
    any1_branch_arbiter #(.CNT_RST_VAL(32'hFFFF_FFFD)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_v_i(v0), .req0_rdy_o(s_rdy0), .req0_inst_i(inst0), .req0_a_i(a0), .req0_b_i(b0),
        .req0_pc_i(pc0), .req0_tgt_i(tgt0), .req0_pred_i(pred0), .req0_tag_i(tag0),
        .req1_v_i(v1), .req1_rdy_o(s_rdy1), .req1_inst_i(inst1), .req1_a_i(a1), .req1_b_i(b1),
        .req1_pc_i(pc1), .req1_tgt_i(tgt1), .req1_pred_i(pred1), .req1_tag_i(tag1),
        .flush_i(flush), .res_v_o(s_res_v), .res_rdy_i(res_rdy), .res_src_o(s_res_src),
        .res_tag_o(s_res_tag), .res_takb_o(s_res_takb), .res_mispred_o(s_res_mis), .res_npc_o(s_res_npc),
        .cnt_br_o(s_cnt_br), .cnt_mis_o(s_cnt_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic br_taken(input logic [7:0] op, input Value a, input Value b);
        case (op)
            OP_BEQ:  return a == b;
            OP_BNE:  return a != b;
            OP_BLT:  return $signed(a) <  $signed(b);
            OP_BGE:  return $signed(a) >= $signed(b);
            OP_BLTU: return a <  b;
            OP_BGEU: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // ---------------- transaction model ----------------
    int m_phase;          // 0 nothing held, 1 op being evaluated, 2 result waiting
    logic m_ptr;
    logic l_src, l_pred;
    logic [3:0] l_tag;
    Instruction l_inst;
    Value l_a, l_b;
    Address l_pc, l_tgt;
    logic r_src, r_takb, r_mis;
    logic [3:0] r_tag;
    Address r_npc;
    longint n_br, n_mis;

    function automatic logic [31:0] sat_from(input longint base, input longint n);
        longint s;
        s = base + n;
        return (s > 64'sh0_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    always @(negedge clk) begin
        logic eg, ew;
        if (!rst_n) begin
            m_phase = 0; m_ptr = 1'b0; n_br = 0; n_mis = 0;
            l_src = 1'b0; l_pred = 1'b0; l_tag = '0; l_inst = '0; l_a = '0; l_b = '0; l_pc = '0; l_tgt = '0;
            r_src = 1'b0; r_takb = 1'b0; r_mis = 1'b0; r_tag = '0; r_npc = '0;
        end
        eg = rst_n && !flush && (v0 || v1) && (m_phase == 0 || (m_phase == 2 && res_rdy));
        ew = (v0 && v1) ? m_ptr : v1;
        chk("m_rdy0", rdy0, eg && !ew);
        chk("m_rdy1", rdy1, eg && ew);
        chk("m_res_v", res_v, m_phase == 2);
        chk("m_src", res_src, r_src);
        chk("m_tag", res_tag, r_tag);
        chk("m_takb", res_takb, r_takb);
        chk("m_mis", res_mis, r_mis);
        chk("m_npc", res_npc, r_npc);
        chk("m_cnt_br", cnt_br, sat_from(0, n_br));
        chk("m_cnt_mis", cnt_mis, sat_from(0, n_mis));
        chk("m_sat_br", s_cnt_br, sat_from(64'h0_FFFF_FFFD, n_br));
        chk("m_sat_mis", s_cnt_mis, sat_from(64'h0_FFFF_FFFD, n_mis));
        if (rst_n) begin
            if (flush) begin
                m_phase = 0;
            end else begin
                if (m_phase == 2 && res_rdy) begin
                    n_br++;
                    if (r_mis) n_mis++;
                    m_phase = 0;
                end else if (m_phase == 1) begin
                    r_src  = l_src;
                    r_tag  = l_tag;
                    r_takb = br_taken(l_inst[7:0], l_a, l_b);
                    r_mis  = (r_takb != l_pred);
                    r_npc  = r_takb ? l_tgt : l_pc + 32'd4;
                    m_phase = 2;
                end
                if (eg) begin
                    l_src  = ew;
                    l_inst = ew ? inst1 : inst0;
                    l_a    = ew ? a1 : a0;
                    l_b    = ew ? b1 : b0;
                    l_pc   = ew ? pc1 : pc0;
                    l_tgt  = ew ? tgt1 : tgt0;
                    l_pred = ew ? pred1 : pred0;
                    l_tag  = ew ? tag1 : tag0;
                    m_ptr  = !ew;
                    m_phase = 1;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic [7:0] op, input Value a, input Value b,
                           input Address pc, input Address tgt, input logic pred, input logic [3:0] tag);
        if (n == 0) begin
            inst0 = {24'hABCDEF, op}; a0 = a; b0 = b; pc0 = pc; tgt0 = tgt; pred0 = pred; tag0 = tag;
        end else begin
            inst1 = {24'h123456, op}; a1 = a; b1 = b; pc1 = pc; tgt1 = tgt; pred1 = pred; tag1 = tag;
        end
    endtask

    // Single op from IDLE with res_rdy_i=1; returns after the delivering edge.
    task automatic do_op(input int n, input logic etakb, input logic emis, input Address enpc, input string nm);
        if (n == 0) v0 = 1'b1; else v1 = 1'b1;
        @(negedge clk);
        chk({nm, "_rdy"}, (n == 0) ? rdy0 : rdy1, 1'b1);
        nxt();
        v0 = 1'b0; v1 = 1'b0;
        @(negedge clk);
        chk({nm, "_eval_v"}, res_v, 1'b0);
        nxt();
        @(negedge clk);
        chk({nm, "_v"}, res_v, 1'b1);
        chk({nm, "_takb"}, res_takb, etakb);
        chk({nm, "_mis"}, res_mis, emis);
        chk({nm, "_npc"}, res_npc, enpc);
        chk({nm, "_src"}, res_src, n[0]);
        nxt();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; res_rdy = 1'b1; v0 = 1'b0; v1 = 1'b0;
        set_req(0, OP_BEQ, 64'd5, 64'd5, 32'h100, 32'h200, 1'b0, 4'd3);
        set_req(1, OP_BEQ, 64'd0, 64'd1, 32'h0, 32'h0, 1'b0, 4'd0);
        v0 = 1'b1;
        @(negedge clk);
        chk("rst_rdy0", rdy0, 1'b0);
        chk("rst_res_v", res_v, 1'b0);
        chk("rst_cnt_br", cnt_br, 32'd0);
        chk("rst_npc", res_npc, 32'd0);
        nxt();
        rst_n = 1'b1;
        // BEQ taken against a not-taken prediction.
        do_op(0, 1'b1, 1'b1, 32'h200, "beq");
        @(negedge clk);
        chk("beq_cnt_br", cnt_br, 32'd1);
        chk("beq_cnt_mis", cnt_mis, 32'd1);
        nxt();

        // Sole requester wins although the pointer favours the other side.
        set_req(0, OP_BLTU, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32'h1000, 32'h2000, 1'b1, 4'd1);
        do_op(0, 1'b1, 1'b0, 32'h2000, "bltu");
        set_req(1, OP_BLT, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32'h1000, 32'h2000, 1'b1, 4'd2);
        do_op(1, 1'b0, 1'b1, 32'h1004, "blt");

        // Both requesters continuously valid: grants alternate, result every 2 cycles.
        set_req(0, OP_BNE, 64'd1, 64'd2, 32'h300, 32'h340, 1'b1, 4'd5);
        set_req(1, OP_BGE, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 32'h400, 32'h500, 1'b1, 4'd9);
        v0 = 1'b1; v1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rr_rdy0", rdy0, (i % 4) == 0);
            chk("rr_rdy1", rdy1, (i % 4) == 2);
            chk("rr_res_v", res_v, (i >= 2) && ((i % 2) == 0));
            if (i == 4) chk("rr_npc1", res_npc, 32'h404);
            nxt();
        end
        v0 = 1'b0; v1 = 1'b0;
        @(negedge clk);
        chk("rr_last_src", res_src, 1'b1);
        nxt();
        @(negedge clk);
        chk("rr_cnt_br", cnt_br, 32'd7);
        chk("rr_cnt_mis", cnt_mis, 32'd4);

        // Back-pressure: five stalled OUT cycles, refill on the cycle res_rdy_i rises.
        nxt();
        res_rdy = 1'b0;
        set_req(0, OP_BGEU, 64'd2, 64'd1, 32'h580, 32'h600, 1'b0, 4'd6);
        set_req(1, OP_BEQ, 64'd7, 64'd8, 32'h700, 32'h780, 1'b0, 4'd7);
        v0 = 1'b1; v1 = 1'b1;
        @(negedge clk);
        chk("bp_rdy0", rdy0, 1'b1);
        nxt();
        v0 = 1'b0;
        @(negedge clk);
        nxt();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_v", res_v, 1'b1);
            chk("bp_hold_npc", res_npc, 32'h600);
            chk("bp_hold_rdy1", rdy1, 1'b0);
            nxt();
        end
        res_rdy = 1'b1;
        @(negedge clk);
        chk("bp_refill_rdy1", rdy1, 1'b1);
        nxt();
        v1 = 1'b0;
        @(negedge clk);
        nxt();
        @(negedge clk);
        chk("bp_npc1", res_npc, 32'h704);
        nxt();

        // Flush in EVAL, then flush in OUT while res_rdy_i=1.
        set_req(0, OP_BEQ, 64'd1, 64'd1, 32'h980, 32'hA00, 1'b0, 4'd4);
        v0 = 1'b1;
        @(negedge clk);
        nxt();
        v0 = 1'b0; flush = 1'b1; v1 = 1'b1;
        @(negedge clk);
        chk("fl_eval_rdy1", rdy1, 1'b0);
        nxt();
        flush = 1'b0; v1 = 1'b0;
        @(negedge clk);
        chk("fl_eval_idle", res_v, 1'b0);
        nxt();
        v0 = 1'b1;
        @(negedge clk);
        nxt();
        v0 = 1'b0;
        @(negedge clk);
        nxt();
        flush = 1'b1; v1 = 1'b1;
        @(negedge clk);
        chk("fl_out_v", res_v, 1'b1);
        chk("fl_out_rdy1", rdy1, 1'b0);
        nxt();
        flush = 1'b0; v1 = 1'b0;
        @(negedge clk);
        chk("fl_out_idle", res_v, 1'b0);
        chk("fl_cnt_br", cnt_br, 32'd9);
        chk("fl_cnt_mis", cnt_mis, 32'd5);
        nxt();

        // Asynchronous reset in the middle of EVAL.
        v0 = 1'b1;
        @(negedge clk);
        nxt();
        v0 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_res_v", res_v, 1'b0);
        chk("ar_npc", res_npc, 32'd0);
        chk("ar_cnt_br", cnt_br, 32'd0);
        chk("ar_sat_br", s_cnt_br, 32'hFFFF_FFFD);
        @(negedge clk);
        nxt();
        rst_n = 1'b1;

        // Counters saturate at all-ones.
        set_req(0, OP_BNE, 64'd1, 64'd2, 32'h800, 32'h900, 1'b0, 4'd8);
        for (int i = 0; i < 4; i++) begin
            do_op(0, 1'b1, 1'b1, 32'h900, "sat");
        end
        @(negedge clk);
        chk("sat_br", s_cnt_br, 32'hFFFF_FFFF);
        chk("sat_mis", s_cnt_mis, 32'hFFFF_FFFF);
        chk("sat_plain_br", cnt_br, 32'd4);
        nxt();
        nxt();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/any1_branch_arbiter.md
ANY1_BRANCH_ARBITER -- requirements
Module: any1_branch_arbiter

Interface
REQ-001 SHALL have parameter INST_BYTES, default 4: PC increment for the not-taken path.
REQ-002 SHALL have parameter TAGW, default 4: width of the request tag.
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports reqN_v_i  input  1  request valid, for N=0,1.
REQ-006 SHALL have ports reqN_rdy_o  output  1  request accepted this cycle.
REQ-007 SHALL have ports reqN_inst_i  input  Instruction  branch instruction (opcode selects condition).
REQ-008 SHALL have ports reqN_a_i, reqN_b_i  input  Value  compare operands.
REQ-009 SHALL have ports reqN_pc_i, reqN_tgt_i  input  Address  branch PC and taken target.
REQ-010 SHALL have ports reqN_pred_i  input  1  predicted-taken; reqN_tag_i  input  TAGW  requester tag.
REQ-011 SHALL have port flush_i  input  1  discard all in-flight work.
REQ-012 SHALL have ports res_v_o  output  1, res_rdy_i  input  1: result handshake.
REQ-013 SHALL have ports res_src_o 1, res_tag_o TAGW, res_takb_o 1, res_mispred_o 1, res_npc_o Address: result fields.
REQ-014 SHALL have ports cnt_br_o, cnt_mis_o  output  32  resolved-branch and mispredict counters.

Function
REQ-015 SHALL share one condition evaluator between two requesters.
REQ-016 SHALL implement FSM states IDLE, EVAL, OUT.
REQ-017 SHALL accept a request only in IDLE, or in OUT with res_rdy_i=1 (same-cycle drain-and-refill).
REQ-018 SHALL arbitrate round-robin: pointer names the preferred requester; a sole valid requester wins regardless of pointer.
REQ-019 SHALL toggle the pointer to the non-granted side after every grant; no toggle without a grant.
REQ-020 SHALL assert at most one reqN_rdy_o per cycle, and only for a requester with reqN_v_i=1.
REQ-021 SHALL latch inst, a, b, pc, tgt, pred, tag and source index on a grant; transition to EVAL.
REQ-022 SHALL, in EVAL, evaluate the latched operands and register takb, mispred=(takb!=pred), npc=takb?tgt:pc+INST_BYTES (modulo Address width); transition to OUT.
REQ-023 SHALL hold res_v_o=1 with stable result fields throughout OUT until res_rdy_i=1.
REQ-024 SHALL leave OUT on res_rdy_i=1 to EVAL (new grant) or IDLE (no grant).
REQ-025 SHALL give a latency of exactly 2 cycles from grant edge to res_v_o=1.
REQ-026 SHALL not let res_v_o depend combinationally on res_rdy_i.
REQ-027 SHALL, on flush_i=1, deassert both reqN_rdy_o that cycle, drop any latched/result op without handshake, and enter IDLE next cycle.
REQ-028 SHALL give flush_i priority over a simultaneous res_rdy_i handshake (result counts as not delivered).
REQ-029 SHALL treat a non-branch opcode as not-taken (takb=0).
REQ-030 SHALL increment cnt_br_o on each completed result handshake, and cnt_mis_o when that result has mispred=1; both saturate at 32'hFFFFFFFF.

Reset
REQ-031 SHALL on rst_ni=0 immediately force state IDLE, pointer=0, res_v_o=0, reqN_rdy_o=0, counters=0, result fields=0.
REQ-032 SHALL discard any in-flight op when reset is asserted mid-operation; first grant possible on the first edge after rst_ni rises.

Structure
REQ-033 SHALL take Instruction, Value, Address and branch opcode constants from any1_pkg; the FSM state enum SHALL be added to any1_pkg.
REQ-034 SHALL instantiate any1_eval_branch once as the shared condition sub-module; no other sub-modules.

Verification
REQ-035 SHALL cover: req0 BEQ a=5,b=5,pc=0x100,tgt=0x200,pred=0, res_rdy_i=1 -> res_v_o 2 cycles after grant, takb=1, mispred=1, npc=0x200, cnt_mis_o=1.
REQ-036 SHALL cover: both requesters valid continuously, res_rdy_i=1 -> grants alternate 0,1,0,1, with a result every 2 cycles.
REQ-037 SHALL cover: BLTU a=1,b=0xFFFFFFFFFFFFFFFF, pc=0x1000, pred=1 -> takb=1, mispred=0; BLT same operands -> takb=0, npc=0x1004.
REQ-038 SHALL cover: res_rdy_i=0 for 5 cycles in OUT -> res fields stable, no reqN_rdy_o, grant occurs on the cycle res_rdy_i rises.
REQ-039 SHALL cover: flush_i in EVAL and in OUT with res_rdy_i=1 -> IDLE next cycle, no result delivered, counters unchanged.
REQ-040 SHALL cover: rst_ni pulsed low mid-EVAL asynchronously -> outputs zero at once; cnt_br_o preloaded near max -> saturates at 32'hFFFFFFFF.
